// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, then a four-state stability FSM
// that produces a debounced level, one-cycle rise/fall strobes and a busy flag.
module btn_debounce #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE_LOW,
        CNT_HIGH,
        IDLE_HIGH,
        CNT_LOW
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_s;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             r_fall;
    logic             w_fall_nxt;
    logic             r_busy;
    logic             w_busy_nxt;

    // NOTE: non-blocking assignments let both synchronizer flops sample in the
    // same edge; blocking would collapse them into a single stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_s     <= 1'b0;
        end else begin
            r_sync1 <= btn_in;
            r_s     <= r_sync1;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        unique case (r_state)
            IDLE_LOW: begin
                if (r_s) begin
                    w_state_nxt = CNT_HIGH;
                    w_cnt_nxt   = ONE;
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            CNT_HIGH: begin
                if (!r_s) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end
            IDLE_HIGH: begin
                if (!r_s) begin
                    w_state_nxt = CNT_LOW;
                    w_cnt_nxt   = ONE;
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            CNT_LOW: begin
                if (r_s) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE_LOW;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
        // busy is registered from the next state so it matches r_state exactly
        w_busy_nxt = (w_state_nxt == CNT_HIGH) || (w_state_nxt == CNT_LOW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;
    assign busy  = r_busy;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with STABLE_CYCLES=4, CNT_W=3; outputs are
// sampled on the falling clock edge, inputs change on the falling edge too.
module tb_btn_debounce;

    localparam int SC = 4;
    localparam int CW = 3;

    logic clk;
    logic rst;
    logic btn_in;
    logic level;
    logic rise;
    logic fall;
    logic busy;

    int n_checks;
    int n_errors;
    int n_rise;
    int n_fall;
    int n_busy;

    btn_debounce #(
        .STABLE_CYCLES(SC),
        .CNT_W        (CW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn_in(btn_in),
        .level (level),
        .rise  (rise),
        .fall  (fall),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic l, input logic r,
                              input logic f, input logic b);
        check({tag, "_level"}, level, l);
        check({tag, "_rise"},  rise,  r);
        check({tag, "_fall"},  fall,  f);
        check({tag, "_busy"},  busy,  b);
    endtask

    // One clock: advance through a rising edge, sample on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (rise) n_rise++;
        if (fall) n_fall++;
        if (busy) n_busy++;
        if (rise && fall) begin
            check("strobe_exclusive", rise & fall, 1'b0);
        end
    endtask

    logic pat [14];

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_rise   = 0;
        n_fall   = 0;
        n_busy   = 0;
        rst      = 1'b1;
        btn_in   = 1'b1;
        pat      = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset held with the button pressed: everything low.
        step();
        step();
        expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        btn_in = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        expect_out("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Clean press: first sample at edge 1, rise after edge SC+2.
        btn_in = 1'b1;
        for (int e = 1; e <= SC + 3; e++) begin
            step();
            expect_out($sformatf("press_e%0d", e), e >= SC + 2, e == SC + 2,
                       1'b0, (e >= 3) && (e <= SC + 1));
        end
        repeat (20 - (SC + 3)) step();
        check_int("press_rise_count", n_rise, 1);
        check("press_level_held", level, 1'b1);

        // Clean release, mirror timing.
        btn_in = 1'b0;
        for (int e = 1; e <= SC + 3; e++) begin
            step();
            expect_out($sformatf("release_e%0d", e), e < SC + 2, 1'b0,
                       e == SC + 2, (e >= 3) && (e <= SC + 1));
        end
        repeat (20 - (SC + 3)) step();
        check_int("release_fall_count", n_fall, 1);
        check_int("release_rise_count", n_rise, 1);

        // Bounce rejection: 3 high / 1 low, five times, then low.
        n_busy = 0;
        repeat (5) begin
            btn_in = 1'b1;
            repeat (3) step();
            btn_in = 1'b0;
            step();
        end
        repeat (8) step();
        check_int("bounce_rise_count", n_rise, 1);
        check_int("bounce_fall_count", n_fall, 1);
        check("bounce_level", level, 1'b0);
        check("bounce_busy_seen", n_busy > 0, 1'b1);
        check("bounce_busy_idle", busy, 1'b0);

        // Bounce then settle: rise only after the 4th consecutive high s sample.
        for (int i = 0; i < 14; i++) begin
            btn_in = pat[i];
            step();
            check($sformatf("settle_rise_%0d", i), rise, i == 10);
        end
        check_int("settle_rise_count", n_rise, 2);
        check("settle_level", level, 1'b1);
        btn_in = 1'b0;
        repeat (8) step();
        check_int("settle_fall_count", n_fall, 2);
        check("settle_level_low", level, 1'b0);

        // Boundary: 3 high samples reject, 4 high samples qualify.
        btn_in = 1'b1;
        repeat (3) step();
        btn_in = 1'b0;
        repeat (8) step();
        check_int("bound3_rise_count", n_rise, 2);
        check("bound3_level", level, 1'b0);
        btn_in = 1'b1;
        repeat (4) step();
        btn_in = 1'b0;
        repeat (10) step();
        check_int("bound4_rise_count", n_rise, 3);
        check_int("bound4_fall_count", n_fall, 3);
        check("bound4_level", level, 1'b0);

        // Reset in the middle of a CNT_HIGH qualification.
        btn_in = 1'b1;
        repeat (4) step();
        check("midcnt_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        expect_out("midcnt_async", 1'b0, 1'b0, 1'b0, 1'b0);
        check_int("midcnt_counter", int'(dut.r_cnt), 0);
        @(negedge clk);
        step();
        step();
        expect_out("midcnt_held", 1'b0, 1'b0, 1'b0, 1'b0);
        check_int("midcnt_rise_count", n_rise, 3);

        // Button still pressed at reset release: treated as a new press.
        rst = 1'b0;
        for (int e = 1; e <= SC + 3; e++) begin
            step();
            expect_out($sformatf("relhigh_e%0d", e), e >= SC + 2, e == SC + 2,
                       1'b0, (e >= 3) && (e <= SC + 1));
        end
        check_int("relhigh_rise_count", n_rise, 4);

        // Asynchronous reset forces a high level low immediately.
        rst = 1'b1;
        #1;
        expect_out("async_from_high", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
